// File: rtl/axis_mux_pkg.sv
// Shared types and helpers for the N-to-1 AXI-Stream multiplexer.
package axis_mux_pkg;

    // Upper bound on channel count handled by the round-robin helper.
    localparam int unsigned MAX_CH = 64;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } rr_grant_t;

    // Ceiling log2 with a floor of 1 so a select port always exists.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // First requesting channel at or after (last+1) mod ch, wrapping once.
    function automatic rr_grant_t rr_next(input logic [MAX_CH-1:0] valid,
                                          input int unsigned       ch,
                                          input int unsigned       last);
        rr_grant_t   g;
        int unsigned k;
        g = '0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            k = (last + i) % ch;
            if (i <= ch && !g.hit && valid[k]) begin
                g.hit = 1'b1;
                g.idx = k;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/axis_mux_n_skid_buf.sv
// axis_skid_buf: two-entry AXI-Stream register slice (output register plus
// skid register). Upstream ready is a flop, so there is no combinational path
// from m_tready to s_tready.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_last;
    logic             skid_valid;

    assign s_tready = ~skid_valid;

    // Output register refills from the skid entry first, then from upstream;
    // a beat arriving while the output stalls parks in the skid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            m_tvalid   <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!m_tvalid || m_tready) begin
            if (skid_valid) begin
                m_tdata    <= skid_data;
                m_tlast    <= skid_last;
                m_tvalid   <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                m_tvalid <= s_tvalid;
                if (s_tvalid) begin
                    m_tdata <= s_tdata;
                    m_tlast <= s_tlast;
                end
            end
        end else if (s_tvalid && !skid_valid) begin
            skid_data  <= s_tdata;
            skid_last  <= s_tlast;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_mux_n.sv
// axis_mux_n: N-to-1 AXI-Stream multiplexer with frame-locked switching and a
// registered output stage. A channel is locked at a frame boundary and held
// until its tlast beat is accepted.
// Build option: define AXIS_MUX_N_RR_EN to replace explicit `sel` control
// with round-robin arbitration among valid channels.
module axis_mux_n
    import axis_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 1,
    parameter  int unsigned CH    = 4,
    localparam int unsigned SEL_W = clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    sel,
    input  logic [CH*WIDTH-1:0] s_axis_tdata,
    input  logic [CH-1:0]       s_axis_tvalid,
    input  logic [CH-1:0]       s_axis_tlast,
    output logic [CH-1:0]       s_axis_tready,
    output logic [WIDTH-1:0]    m_axis_tdata,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    output logic [SEL_W-1:0]    cur_ch,
    output logic                busy
);

    state_t           state;
    state_t           state_next;
    logic             req_hit;
    logic [SEL_W-1:0] req_idx;
    logic [WIDTH-1:0] mux_data;
    logic             mux_valid;
    logic             mux_last;
    logic             buf_ready;

`ifdef AXIS_MUX_N_RR_EN
    logic [SEL_W-1:0]  last_grant;
    logic [MAX_CH-1:0] valid_pad;
    rr_grant_t         grant;
    logic              unused_rr;

    assign unused_rr = ^{sel, grant.idx};

    // Round-robin request: first valid channel after the previous grant.
    always_comb begin
        valid_pad          = '0;
        valid_pad[CH-1:0]  = s_axis_tvalid;
        grant              = rr_next(valid_pad, CH, 32'(last_grant));
        req_hit            = grant.hit;
        req_idx            = grant.idx[SEL_W-1:0];
    end

    // Remember the most recent grant; reset value gives channel 0 first turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= SEL_W'(CH - 1);
        end else if (state == IDLE && req_hit) begin
            last_grant <= req_idx;
        end
    end
`else
    // Explicit request: out-of-range sel values never match a channel.
    always_comb begin
        req_hit = 1'b0;
        req_idx = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (sel == SEL_W'(k) && s_axis_tvalid[k]) begin
                req_hit = 1'b1;
                req_idx = SEL_W'(k);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: lock on a request, release once the tlast beat is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_hit) state_next = LOCK;
            LOCK: if (mux_valid && buf_ready && mux_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: route the locked channel into the buffer and return its ready.
    always_comb begin
        busy          = (state == LOCK);
        s_axis_tready = '0;
        mux_data      = '0;
        mux_valid     = 1'b0;
        mux_last      = 1'b0;
        for (int unsigned k = 0; k < CH; k++) begin
            if (cur_ch == SEL_W'(k)) begin
                mux_data         = s_axis_tdata[k*WIDTH +: WIDTH];
                mux_last         = s_axis_tlast[k];
                mux_valid        = (state == LOCK) && s_axis_tvalid[k];
                s_axis_tready[k] = (state == LOCK) && buf_ready;
            end
        end
    end

    // Latch the granted channel at the frame boundary; hold it through LOCK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch <= '0;
        end else if (state == IDLE && req_hit) begin
            cur_ch <= req_idx;
        end
    end

    axis_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (mux_data),
        .s_tvalid (mux_valid),
        .s_tlast  (mux_last),
        .s_tready (buf_ready),
        .m_tdata  (m_axis_tdata),
        .m_tvalid (m_axis_tvalid),
        .m_tlast  (m_axis_tlast),
        .m_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_axis_mux_n.sv
// Self-checking bench for axis_mux_n (CH=5, WIDTH=8) with a queue-based
// reference model and per-channel frame sources.
`timescale 1ns/1ps
module tb_axis_mux_n;

    localparam int W   = 8;
    localparam int NCH = 5;
    localparam int SW  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SW-1:0]     sel = '0;
    logic [NCH*W-1:0]  s_axis_tdata = '0;
    logic [NCH-1:0]    s_axis_tvalid = '0;
    logic [NCH-1:0]    s_axis_tlast = '0;
    logic [NCH-1:0]    s_axis_tready;
    logic [W-1:0]      m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b0;
    logic [SW-1:0]     cur_ch;
    logic              busy;

    axis_mux_n #(.WIDTH(W), .CH(NCH)) dut (
        .clk           (clk),
        .rst           (rst),
        .sel           (sel),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .cur_ch        (cur_ch),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic l; logic [W-1:0] d; } beat_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- per-channel frame sources ----------------
    logic [W:0] src_mem [NCH][4096];
    int         src_head [NCH];
    int         src_tail [NCH];

    task automatic push(input int ch, input logic [W-1:0] d, input bit l);
        src_mem[ch][src_tail[ch]] = {l, d};
        src_tail[ch]++;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++)
            if (s_axis_tvalid[k] && s_axis_tready[k] && src_head[k] < src_tail[k])
                src_head[k]++;
        #2;
        for (int k = 0; k < NCH; k++) begin
            if (src_head[k] < src_tail[k]) begin
                s_axis_tvalid[k] = 1'b1;
                {s_axis_tlast[k], s_axis_tdata[k*W +: W]} = src_mem[k][src_head[k]];
            end else begin
                s_axis_tvalid[k]        = 1'b0;
                s_axis_tlast[k]         = 1'b0;
                s_axis_tdata[k*W +: W]  = '0;
            end
        end
    end

    // ---------------- reference model ----------------
    beat_t mq[$];
    bit    m_locked     = 1'b0;
    int    m_ch         = 0;
    int    m_last_grant = NCH - 1;
    bit    m_zero       = 1'b1;

    function automatic int model_pick();
`ifdef AXIS_MUX_N_RR_EN
        for (int i = 1; i <= NCH; i++)
            if (s_axis_tvalid[(m_last_grant + i) % NCH]) return (m_last_grant + i) % NCH;
        return -1;
`else
        if (int'(sel) < NCH && s_axis_tvalid[sel]) return int'(sel);
        return -1;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin : model_upd
        bit acc;
        bit drain;
        int pick;
        if (rst) begin
            mq.delete();
            m_locked     = 1'b0;
            m_ch         = 0;
            m_last_grant = NCH - 1;
            m_zero       = 1'b1;
        end else begin
            acc   = m_locked && s_axis_tvalid[m_ch] && mq.size() < 2;
            drain = mq.size() > 0 && m_axis_tready;
            if (drain) void'(mq.pop_front());
            if (acc) begin
                mq.push_back({s_axis_tlast[m_ch], s_axis_tdata[m_ch*W +: W]});
                m_zero = 1'b0;
            end
            if (m_locked) begin
                if (acc && s_axis_tlast[m_ch]) m_locked = 1'b0;
            end else begin
                pick = model_pick();
                if (pick >= 0) begin
                    m_locked     = 1'b1;
                    m_ch         = pick;
                    m_last_grant = pick;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin : compare
        logic [NCH-1:0] er;
        er = '0;
        if (m_locked && mq.size() < 2) er[m_ch] = 1'b1;
        check("s_tready", 32'(s_axis_tready), 32'(er));
        check("busy",     32'(busy),          32'(m_locked));
        check("cur_ch",   32'(cur_ch),        32'(m_ch));
        check("m_tvalid", 32'(m_axis_tvalid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("m_tdata", 32'(m_axis_tdata), 32'(mq[0].d));
            check("m_tlast", 32'(m_axis_tlast), 32'(mq[0].l));
        end else if (m_zero) begin
            check("m_tdata_zero", 32'(m_axis_tdata), 32'h0);
            check("m_tlast_zero", 32'(m_axis_tlast), 32'h0);
        end
    end

    // ---------------- output log ----------------
    beat_t out_log[$];
    int    out_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            out_log.push_back({m_axis_tlast, m_axis_tdata});
            out_cyc.push_back(cyc);
        end
    end

    function automatic bit all_idle();
        for (int k = 0; k < NCH; k++)
            if (src_head[k] < src_tail[k]) return 1'b0;
        return mq.size() == 0 && !m_locked;
    endfunction

    task automatic wait_idle(input int budget, input bit rnd, input bit auto_sel);
        int n;
        n = 0;
        while (n < budget && !all_idle()) begin
            @(posedge clk);
            #3;
            m_axis_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (auto_sel)
                for (int k = NCH - 1; k >= 0; k--)
                    if (src_head[k] < src_tail[k]) sel = SW'(k);
            n++;
        end
        n_checks++;
        if (!all_idle()) begin
            n_fail++;
            $display("FAIL wait_idle: not idle after %0d cycles, required idle", budget);
        end
        m_axis_tready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        int n;
        int len;
        int ch;

        // Reset state
        @(posedge clk);
        #2;
        check("rst_tready", 32'(s_axis_tready), 32'h0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("rst_tdata",  32'(m_axis_tdata),  32'h0);
        check("rst_tlast",  32'(m_axis_tlast),  32'h0);
        check("rst_busy",   32'(busy),          32'h0);
        check("rst_cur_ch", 32'(cur_ch),        32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        m_axis_tready = 1'b1;

`ifdef AXIS_MUX_N_RR_EN
        // Round-robin: all channels hold two 2-beat frames
        @(negedge clk);
        out_log.delete(); out_cyc.delete();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < NCH; k++) begin
                push(k, 8'(k * 16 + f * 2), 1'b0);
                push(k, 8'(k * 16 + f * 2 + 1), 1'b1);
            end
        wait_idle(200, 1'b0, 1'b0);
        check("rr_count", 32'(out_log.size()), 32'(4 * NCH));
        if (out_log.size() == 4 * NCH)
            for (int j = 0; j < 2 * NCH; j++)
                check("rr_order", 32'(out_log[2*j].d[7:4]), 32'(j % NCH));
`endif

        // Basic pass-through on channel 2
        sel = 3'd2;
        @(negedge clk);
        out_log.delete(); out_cyc.delete();
        push(2, 8'h10, 1'b0);
        push(2, 8'h11, 1'b0);
        push(2, 8'h12, 1'b1);
        @(negedge clk);
        check("grant_pre_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("grant_busy",  32'(busy),          32'h1);
        check("grant_ready", 32'(s_axis_tready), 32'h04);
        wait_idle(50, 1'b0, 1'b0);
        check("basic_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("basic_data", 32'(out_log[i].d), 32'(16 + i));
                check("basic_last", 32'(out_log[i].l), 32'(i == 2));
            end
            check("basic_consec", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        end

        // Frame lock: sel moves 2 -> 1 mid-frame
        @(negedge clk);
        out_log.delete(); out_cyc.delete();
        sel = 3'd2;
        for (int i = 0; i < 4; i++) push(2, 8'(8'h20 + i), i == 3);
        for (int i = 0; i < 3; i++) push(1, 8'(8'h30 + i), i == 2);
        n = 0;
        while (out_log.size() < 2 && n < 50) begin @(negedge clk); n++; end
        sel = 3'd1;
        wait_idle(60, 1'b0, 1'b1);
`ifndef AXIS_MUX_N_RR_EN
        check("lock_count", 32'(out_log.size()), 32'd7);
        if (out_log.size() == 7) begin
            for (int i = 0; i < 4; i++) check("lock_ch2", 32'(out_log[i].d), 32'(32 + i));
            for (int i = 0; i < 3; i++) check("lock_ch1", 32'(out_log[4+i].d), 32'(48 + i));
            check("lock_idle_gap", 32'(out_cyc[4] - out_cyc[3]), 32'd2);
        end
`endif

        // Backpressure: 64-beat counting frame, random downstream ready
        @(negedge clk);
        out_log.delete(); out_cyc.delete();
        sel = 3'd3;
        for (int i = 0; i < 64; i++) push(3, 8'(i), i == 63);
        wait_idle(800, 1'b1, 1'b0);
        check("bp_count", 32'(out_log.size()), 32'd64);
        if (out_log.size() == 64)
            for (int i = 0; i < 64; i++) begin
                check("bp_data", 32'(out_log[i].d), 32'(i));
                check("bp_last", 32'(out_log[i].l), 32'(i == 63));
            end

        // Invalid select with every channel valid
        @(negedge clk);
        sel = 3'd5;
        for (int k = 0; k < NCH; k++)
            for (int i = 0; i < 3; i++) push(k, 8'(8'h60 + k * 4 + i), i == 2);
`ifndef AXIS_MUX_N_RR_EN
        repeat (6) begin
            @(negedge clk);
            check("badsel_busy",  32'(busy),          32'h0);
            check("badsel_ready", 32'(s_axis_tready), 32'h0);
        end
`endif
        wait_idle(300, 1'b0, 1'b1);

        // Reset during beat 3 of an 8-beat frame
        @(negedge clk);
        out_log.delete(); out_cyc.delete();
        sel = 3'd1;
        for (int i = 0; i < 8; i++) push(1, 8'(8'h40 + i), i == 7);
        n = 0;
        while (out_log.size() < 3 && n < 50) begin @(negedge clk); n++; end
        check("mid_rst_reached_beat3", 32'(out_log.size() >= 3), 32'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_tready", 32'(s_axis_tready), 32'h0);
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("mid_rst_tdata",  32'(m_axis_tdata),  32'h0);
        check("mid_rst_tlast",  32'(m_axis_tlast),  32'h0);
        check("mid_rst_busy",   32'(busy),          32'h0);
        check("mid_rst_cur_ch", 32'(cur_ch),        32'h0);
        for (int k = 0; k < NCH; k++) begin src_head[k] = 0; src_tail[k] = 0; end
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'h0);
        out_log.delete(); out_cyc.delete();
        sel = 3'd3;
        for (int i = 0; i < 4; i++) push(3, 8'(8'h50 + i), i == 3);
        wait_idle(50, 1'b0, 1'b0);
        check("post_rst_count", 32'(out_log.size()), 32'd4);
        if (out_log.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check("post_rst_data", 32'(out_log[i].d), 32'(80 + i));
                check("post_rst_last", 32'(out_log[i].l), 32'(i == 3));
            end

        // Randomized traffic: random frames, sel (including invalid), ready
        repeat (600) begin
            @(posedge clk);
            #3;
            sel = SW'($urandom_range(0, 7));
            m_axis_tready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                ch = $urandom_range(0, NCH - 1);
                if (src_tail[ch] - src_head[ch] < 16) begin
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++) push(ch, 8'($urandom), i == len - 1);
                end
            end
        end
        wait_idle(3000, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
